load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised load/store unit between the execute/memory pipeline stage and a data memory with variable latency and a valid/ready handshake.
- Replaces the single-cycle combinational dmem access. Aligns addresses, generates byte masks, and lane-shifts store data.
- Extracts and sign/zero-extends load data, and detects misaligned-access traps.
- Handles one access at a time and provides a stall indication to the pipeline.

Parameters:
- ADDR_W, 32: address width; must be at least 3.
- DATA_W, 32: memory word width; legal values are 32 or 64. LANES = DATA_W/8.
- TIMEOUT, 255: maximum cycles to wait for i_mem_rvalid before a trap is reported. A value of 0 disables the timeout.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  pipeline presents an access
- o_req_ready  out  1  unit accepts the request this cycle; high only in IDLE
- i_req_wen  in  1  1 = store, 0 = load
- i_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_W = 64)
- i_req_unsigned  in  1  zero-extend load data (lbu/lhu)
- i_req_addr  in  ADDR_W  byte address
- i_req_wdata  in  DATA_W  store data, right-justified
- o_resp_valid  out  1  one-cycle pulse: access complete
- o_resp_rdata  out  DATA_W  extended load data; 0 for stores and traps
- o_resp_trap  out  1  qualifies o_resp_valid: misaligned access, illegal size, or timeout
- o_busy  out  1  high from acceptance until the response cycle, inclusive; pipeline stalls on it
- o_mem_req  out  1  memory request valid
- i_mem_ready  in  1  memory accepts the request
- o_mem_addr  out  ADDR_W  address aligned to LANES bytes (low log2(LANES) bits forced to 0)
- o_mem_ren  out  1  read request
- o_mem_wen  out  1  write request; never asserted together with o_mem_ren
- o_mem_wdata  out  DATA_W  store data shifted into its byte lanes
- o_mem_mask  out  LANES  byte-lane enables
- i_mem_rvalid  in  1  read data returned
- i_mem_rdata  in  DATA_W  read word; only masked lanes are valid

Behaviour:
- Reset: state = IDLE and every output register is 0 (o_req_ready comes up 1 because the state is IDLE). The timeout counter is also 0.
- Request capture: the request is registered when i_req_valid && o_req_ready.
- Offset and alignment: offset = addr mod LANES. The access is misaligned when offset is not a multiple of 2^size, or when size exceeds log2(LANES).
- Mask: ((1 << 2^size) - 1) << offset.
- Store data: wdata << (8 * offset).
- Load data: (rdata >> (8 * offset)), truncated to 2^size bytes, then sign-extended (or zero-extended if i_req_unsigned) to DATA_W.
- IDLE:
  - On accept with a trap condition -> RESP with trap = 1. No memory request is issued.
  - On accept with no trap -> ISSUE.
- ISSUE:
  - o_mem_req = 1 and all request fields are held stable until i_mem_ready.
  - On i_mem_ready: a store -> RESP (the write is done); a load -> WAIT.
  - If i_mem_rvalid arrives in the same cycle as i_mem_ready, the data is captured and the FSM goes directly to RESP.
- WAIT:
  - On i_mem_rvalid -> capture the extended data, go to RESP.
  - The counter increments each WAIT cycle. When the count reaches TIMEOUT (and TIMEOUT != 0) -> RESP with trap = 1 and rdata = 0.
  - Any i_mem_rvalid arriving later while in IDLE is ignored.
- RESP: o_resp_valid = 1 for exactly one cycle, then -> IDLE. A new request can be accepted the following cycle.
- Latency: a load with a ready-at-issue, rvalid-next-cycle memory is accepted in cycle N, ISSUE N+1, WAIT N+2 (rvalid seen), RESP N+3. The same store gives RESP N+2; a trap gives RESP N+1.
- i_mem_rvalid outside WAIT/ISSUE: ignored.
- Reset mid-operation: return to IDLE immediately and drop o_mem_req. No response is produced for the aborted access.

Decomposition:
- Shared package lsu_pkg:
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D
  - FSM state encodings: IDLE, ISSUE, WAIT, RESP
  - function lane_mask(size, offset)
- Sub-module lsu_align: purely combinational. Computes the mask, misalign flag, store shift, and load extract/extend, and is shared between the request and response paths. The FSM and counter stay in load_store_unit.

Test Plan:
- Byte store at addr 0x2003, wdata 0x000000AB, memory ready immediately -> o_mem_addr = 0x2000, mask = 0b1000, wdata = 0xAB000000, o_mem_wen pulse, resp_valid 2 cycles after accept, trap = 0.
- Halfword signed load at 0x1002, rdata = 0x8001_xxxx, rvalid 3 cycles after ready -> mask = 0b1100, resp_rdata = 0xFFFF8001. The same access with lhu -> 0x00008001.
- Word load at 0x1001 -> no o_mem_req, resp_valid the next cycle with trap = 1 and rdata = 0.
- i_mem_ready held low 5 cycles -> o_mem_req and all fields stable throughout, o_req_ready = 0, o_busy = 1. The access then completes normally.
- TIMEOUT = 4 with rvalid never asserted -> trap response after 4 WAIT cycles. A later rvalid while IDLE -> no response.
- Reset asserted in WAIT -> IDLE next cycle, o_mem_req = 0, o_resp_valid stays 0. DATA_W = 64 with a double load at 0x8 -> mask = 0xFF, full word returned.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit and its alignment datapath.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Widest memory word is 64 bits, so at most 8 byte lanes.
  localparam int MAX_LANES = 8;

  // Byte-lane enables for an access of 2^size bytes starting at lane offset.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [2:0] offset);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << offset;
    return m[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment datapath: lane mask, misalignment detect, store
// lane shift and load extract/extend. Shared by request and response paths.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          i_size,
  input  logic [OFF_W-1:0]    i_offset,
  input  logic                i_unsigned,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W/8-1:0] o_mask,
  output logic                o_misalign,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int LANES = DATA_W / 8;

  logic [3:0]        w_nbytes;
  logic [3:0]        w_off_ext;
  logic [7:0]        w_mask_full;
  logic              w_unused_mask;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  assign w_nbytes  = 4'd1 << i_size;
  assign w_off_ext = 4'(i_offset);

  // Oversized accesses (e.g. double on a 32-bit bus) are treated as misaligned.
  assign o_misalign = ({2'b00, i_size} > 4'(OFF_W)) ||
                      ((w_off_ext & (w_nbytes - 4'd1)) != 4'd0);

  assign w_mask_full   = lane_mask(i_size, 3'(i_offset));
  assign o_mask        = w_mask_full[LANES-1:0];
  assign w_unused_mask = ^w_mask_full;

  assign o_wdata  = i_wdata << {i_offset, 3'b000};
  assign w_rshift = i_rdata >> {i_offset, 3'b000};

  // Keep mask covering the low 2^size bytes of the shifted read word.
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (4'(i) < w_nbytes) w_keep[8*i +: 8] = 8'hFF;
    end
  end

  // Sign bit is the top bit of the extracted field.
  always_comb begin
    case (i_size)
      SZ_B:    w_sign = w_rshift[7];
      SZ_H:    w_sign = w_rshift[15];
      SZ_W:    w_sign = w_rshift[31];
      default: w_sign = w_rshift[DATA_W-1];
    endcase
  end

  assign o_rdata = (w_rshift & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a variable-latency data memory
// with valid/ready handshake, misalignment and read-timeout traps.
//
// state | meaning
// IDLE  | ready for a request from the pipeline
// ISSUE | memory request held until i_mem_ready
// WAIT  | load issued, waiting for i_mem_rvalid (bounded by TIMEOUT)
// RESP  | one-cycle response pulse to the pipeline
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_resp_trap,
  output logic                o_busy,
  output logic                o_mem_req,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_ren,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            r_state;
  logic              r_wen;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_trap;
  logic              r_busy;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [LANES-1:0]  r_mem_mask;

  logic              w_idle;
  logic              w_accept;
  logic [1:0]        w_al_size;
  logic [OFF_W-1:0]  w_al_off;
  logic              w_al_uns;
  logic [LANES-1:0]  w_mask;
  logic              w_misalign;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_rdata_ext;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = i_req_valid && w_idle;

  // In IDLE the aligner sees the incoming request; afterwards the captured one,
  // so the same instance serves both store shifting and load extraction.
  assign w_al_size = w_idle ? i_req_size                 : r_size;
  assign w_al_off  = w_idle ? i_req_addr[OFF_W-1:0]      : r_off;
  assign w_al_uns  = w_idle ? i_req_unsigned             : r_uns;

  lsu_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .i_size     (w_al_size),
    .i_offset   (w_al_off),
    .i_unsigned (w_al_uns),
    .i_wdata    (i_req_wdata),
    .i_rdata    (i_mem_rdata),
    .o_mask     (w_mask),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_rdata_ext)
  );

  // Access sequencing FSM with registered memory and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_wen        <= 1'b0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_trap  <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_wdata  <= '0;
      r_mem_mask   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen  <= i_req_wen;
            r_size <= i_req_size;
            r_uns  <= i_req_unsigned;
            r_off  <= i_req_addr[OFF_W-1:0];
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_misalign) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_trap  <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= ISSUE;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_mem_ren   <= !i_req_wen;
              r_mem_wen   <= i_req_wen;
              r_mem_wdata <= w_wdata_sh;
              r_mem_mask  <= w_mask;
            end
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            if (r_wen) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_trap  <= 1'b0;
              r_resp_rdata <= '0;
            end else if (i_mem_rvalid) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_trap  <= 1'b0;
              r_resp_rdata <= w_rdata_ext;
            end else begin
              r_state <= WAIT;
              r_cnt   <= '0;
            end
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_trap  <= 1'b0;
            r_resp_rdata <= w_rdata_ext;
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_trap  <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_resp_trap  <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = w_idle;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_trap  = r_resp_trap;
  assign o_busy       = r_busy;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_ren    = r_mem_ren;
  assign o_mem_wen    = r_mem_wen;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_mask   = r_mem_mask;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance (timeout disabled) share stimulus; outputs are muxed by sel64.
module tb_load_store_unit;

  localparam int T32 = 4;
  localparam int T64 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel64;
  logic        req_valid, req_wen, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        v_a, v_b;
  logic        a_req_ready, a_resp_valid, a_resp_trap, a_busy, a_mem_req, a_mem_ren, a_mem_wen;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_mask;
  logic        b_req_ready, b_resp_valid, b_resp_trap, b_busy, b_mem_req, b_mem_ren, b_mem_wen;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_mask;

  logic        req_ready, resp_valid, resp_trap, busy, mem_req, mem_ren, mem_wen;
  logic [63:0] resp_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_mask;

  int n_checks = 0;
  int n_fail   = 0;

  assign v_a = req_valid & ~sel64;
  assign v_b = req_valid & sel64;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T32)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v_a), .o_req_ready(a_req_ready),
    .i_req_wen(req_wen), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata[31:0]),
    .o_resp_valid(a_resp_valid), .o_resp_rdata(a_resp_rdata), .o_resp_trap(a_resp_trap),
    .o_busy(a_busy), .o_mem_req(a_mem_req), .i_mem_ready(mem_ready),
    .o_mem_addr(a_mem_addr), .o_mem_ren(a_mem_ren), .o_mem_wen(a_mem_wen),
    .o_mem_wdata(a_mem_wdata), .o_mem_mask(a_mem_mask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0])
  );

  load_store_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(T64)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v_b), .o_req_ready(b_req_ready),
    .i_req_wen(req_wen), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(b_resp_valid), .o_resp_rdata(b_resp_rdata), .o_resp_trap(b_resp_trap),
    .o_busy(b_busy), .o_mem_req(b_mem_req), .i_mem_ready(mem_ready),
    .o_mem_addr(b_mem_addr), .o_mem_ren(b_mem_ren), .o_mem_wen(b_mem_wen),
    .o_mem_wdata(b_mem_wdata), .o_mem_mask(b_mem_mask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always_comb begin
    if (sel64) begin
      req_ready = b_req_ready; resp_valid = b_resp_valid; resp_trap = b_resp_trap;
      busy = b_busy; mem_req = b_mem_req; mem_ren = b_mem_ren; mem_wen = b_mem_wen;
      resp_rdata = b_resp_rdata; mem_wdata = b_mem_wdata; mem_addr = b_mem_addr;
      mem_mask = b_mem_mask;
    end else begin
      req_ready = a_req_ready; resp_valid = a_resp_valid; resp_trap = a_resp_trap;
      busy = a_busy; mem_req = a_mem_req; mem_ren = a_mem_ren; mem_wen = a_mem_wen;
      resp_rdata = {32'b0, a_resp_rdata}; mem_wdata = {32'b0, a_mem_wdata};
      mem_addr = a_mem_addr; mem_mask = {4'b0, a_mem_mask};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: behaviour of one access derived from the addressing rules.
  function automatic void model(input bit is64, input bit wen, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input int rv_dly,
                                output bit mis, output bit to, output logic [7:0] mask,
                                output logic [31:0] maddr, output logic [63:0] mwdata,
                                output logic [63:0] rexp);
    int lanes, off, nb, tmo;
    logic [127:0] dmask, w, r, lo;
    lanes  = is64 ? 8 : 4;
    tmo    = is64 ? T64 : T32;
    off    = int'(addr[2:0]) % lanes;
    nb     = 1 << size;
    mis    = (nb > lanes) || ((off % nb) != 0);
    mask   = 8'(((1 << nb) - 1) << off);
    maddr  = addr - 32'(off);
    dmask  = is64 ? {64'b0, {64{1'b1}}} : {96'b0, 32'hFFFF_FFFF};
    w      = {64'b0, wdata} & dmask;
    mwdata = 64'((w << (8 * off)) & dmask);
    r      = ({64'b0, rdata} & dmask) >> (8 * off);
    lo     = (128'd1 << (8 * nb)) - 128'd1;
    if (!uns && r[8*nb-1]) r = (r & lo) | ~lo;
    else                   r = r & lo;
    to     = !wen && !mis && (tmo != 0) && (rv_dly > tmo);
    rexp   = (wen || mis || to) ? 64'b0 : 64'(r & dmask);
  endfunction

  // One complete access; rdy_dly = ISSUE cycles with ready low, rv_dly = WAIT
  // cycle carrying rvalid (0: together with ready).
  task automatic do_access(input bit is64, input bit wen, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int rdy_dly, input int rv_dly,
                           output logic [63:0] g_rdata, output logic [7:0] g_mask,
                           output logic [63:0] g_wdata, output logic g_trap);
    bit e_mis, e_to;
    logic [7:0]  e_mask;
    logic [31:0] e_addr;
    logic [63:0] e_wdata, e_rdata;
    int tmo;
    model(is64, wen, size, uns, addr, wdata, rdata, rv_dly,
          e_mis, e_to, e_mask, e_addr, e_wdata, e_rdata);
    tmo = is64 ? T64 : T32;
    g_mask = '0; g_wdata = '0; g_rdata = '0; g_trap = 1'b0;
    sel64 = is64;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = '1;
    if (e_mis) begin
      check("trap_valid", resp_valid, 1);
      check("trap_flag", resp_trap, 1);
      check("trap_rdata", resp_rdata, 0);
      check("trap_no_memreq", mem_req, 0);
      g_rdata = resp_rdata; g_trap = resp_trap;
    end else begin
      check("iss_req", mem_req, 1);
      check("iss_addr", mem_addr, e_addr);
      check("iss_mask", mem_mask, e_mask);
      check("iss_ren", mem_ren, !wen);
      check("iss_wen", mem_wen, wen);
      if (wen) check("iss_wdata", mem_wdata, e_wdata);
      check("iss_req_ready", req_ready, 0);
      check("iss_busy", busy, 1);
      g_mask = mem_mask; g_wdata = mem_wdata;
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, e_addr);
        check("hold_mask", mem_mask, e_mask);
        check("hold_wdata", mem_wdata, g_wdata);
        check("hold_wen", mem_wen, wen);
        check("hold_req_ready", req_ready, 0);
        check("hold_busy", busy, 1);
        check("hold_no_resp", resp_valid, 0);
      end
      mem_ready = 1'b1;
      if (!wen && rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (!wen && rv_dly != 0) begin
        check("wait_no_req", mem_req, 0);
        check("wait_no_resp", resp_valid, 0);
        for (int w = 1; w <= rv_dly; w++) begin
          if (w == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          @(negedge clk);
          mem_rvalid = 1'b0;
          if (w == rv_dly || (tmo != 0 && w == tmo)) break;
          check("wait_no_resp", resp_valid, 0);
        end
      end
      check("resp_valid", resp_valid, 1);
      check("resp_trap", resp_trap, e_to);
      check("resp_rdata", resp_rdata, e_rdata);
      check("resp_busy", busy, 1);
      g_rdata = resp_rdata; g_trap = resp_trap;
    end
    @(negedge clk);
    check("post_resp_valid", resp_valid, 0);
    check("post_busy", busy, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g_rdata, g_wdata;
    logic [7:0]  g_mask;
    logic        g_trap;
    bit          is64, wen, uns;
    logic [1:0]  size;
    logic [31:0] addr;

    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
    req_uns = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_mask", mem_mask, 0);
    end
    sel64 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Byte store at 0x2003.
    do_access(0, 1, 2'd0, 0, 32'h2003, 64'hAB, 64'h0, 0, 0, g_rdata, g_mask, g_wdata, g_trap);
    check("sb_mask", g_mask, 8'h08);
    check("sb_wdata", g_wdata, 64'hAB00_0000);
    check("sb_trap", g_trap, 0);

    // Halfword loads, signed and unsigned, rvalid 3 cycles after ready.
    do_access(0, 0, 2'd1, 0, 32'h1002, 64'h0, 64'h8001_1234, 0, 3, g_rdata, g_mask, g_wdata, g_trap);
    check("lh_mask", g_mask, 8'h0C);
    check("lh_rdata", g_rdata, 64'hFFFF_8001);
    do_access(0, 0, 2'd1, 1, 32'h1002, 64'h0, 64'h8001_1234, 0, 3, g_rdata, g_mask, g_wdata, g_trap);
    check("lhu_rdata", g_rdata, 64'h0000_8001);

    // Misaligned word load.
    do_access(0, 0, 2'd2, 0, 32'h1001, 64'h0, 64'h0, 0, 1, g_rdata, g_mask, g_wdata, g_trap);
    check("lw_mis_trap", g_trap, 1);
    check("lw_mis_rdata", g_rdata, 0);

    // Memory backpressure for 5 cycles.
    do_access(0, 1, 2'd2, 0, 32'h3000, 64'hDEAD_BEEF, 64'h0, 5, 0, g_rdata, g_mask, g_wdata, g_trap);
    check("sw_bp_wdata", g_wdata, 64'hDEAD_BEEF);
    do_access(0, 0, 2'd2, 0, 32'h3004, 64'h0, 64'h1234_5678, 5, 1, g_rdata, g_mask, g_wdata, g_trap);
    check("lw_bp_rdata", g_rdata, 64'h1234_5678);

    // Read timeout, then stray rvalid while idle.
    do_access(0, 0, 2'd2, 0, 32'h4000, 64'h0, 64'h0, 0, 99, g_rdata, g_mask, g_wdata, g_trap);
    check("tmo_trap", g_trap, 1);
    check("tmo_rdata", g_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("idle_rvalid_ignored", resp_valid, 0);
      check("idle_rvalid_ready", req_ready, 1);
    end

    // Reset while in ISSUE and while in WAIT.
    for (int ph = 0; ph < 2; ph++) begin
      sel64 = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h5000;
      @(negedge clk);
      req_valid = 1'b0;
      if (ph == 1) begin
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_mem_req", mem_req, 0);
      check("rst_mid_resp", resp_valid, 0);
      check("rst_mid_ready", req_ready, 1);
      check("rst_mid_busy", busy, 0);
      mem_rvalid = 1'b1; mem_rdata = 64'h7777_7777;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rst_mid_no_resp", resp_valid, 0);
    end

    // 64-bit instance: double load at 0x8.
    do_access(1, 0, 2'd3, 0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1,
              g_rdata, g_mask, g_wdata, g_trap);
    check("ld_mask", g_mask, 8'hFF);
    check("ld_rdata", g_rdata, 64'h0123_4567_89AB_CDEF);
    check("ld_trap", g_trap, 0);

    // Randomised accesses on both widths.
    for (int k = 0; k < 80; k++) begin
      is64 = ((k % 2) == 1);
      wen  = ($urandom_range(0, 1) == 1);
      uns  = ($urandom_range(0, 1) == 1);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
      do_access(is64, wen, size, uns, addr, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), is64 ? $urandom_range(0, 5) : $urandom_range(0, 6),
                g_rdata, g_mask, g_wdata, g_trap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
